// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
//   DIR_UP / DIR_DOWN    : encodings of the up_dn input
//   MODE_WRAP / MODE_SAT : encodings of the sat_mode input
//   clog2()              : bit width needed to hold values 0..v-1
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Minimum width for a counter that runs 0..v-1 (never less than 1 bit).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < v) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Enabled-cycle prescaler: asserts tick on every PRESCALE-th cycle with en=1.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset (restarts the divide sequence)
//   clr  in  synchronous clear, same effect as rst (used on parallel load)
//   en   in  cycle enable; the divider holds while en=0
//   tick out combinational: this enabled cycle completes a PRESCALE group
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned PW = clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;
   logic [PW-1:0] cnt_nxt;

   // Tick on the last enabled cycle of each group.
   always_comb begin
      tick    = 1'b0;
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = '0;
      end else if (en) begin
         if (cnt == LAST) begin
            tick    = 1'b1;
            cnt_nxt = '0;
         end else begin
            cnt_nxt = cnt + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule : counter_prescaler

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with load, wrap/saturate mode,
// a one-cycle wrap pulse and a sticky overflow flag.
// Build option: define COUNTER_PRESCALE_EN to step only on every
// PRESCALE-th enabled cycle (prescaler cleared by rst and load).
// Ports:
//   clk       in  clock
//   rst       in  synchronous active-high reset, overrides everything
//   en        in  count enable
//   up_dn     in  1 = up, 0 = down
//   sat_mode  in  1 = saturate at the limit, 0 = wrap modulo MAX_VAL+1
//   load      in  parallel load strobe (beats en; value clamped to MAX_VAL)
//   load_val  in  load value
//   clr_ovf   in  clears ovf (a same-cycle wrap wins)
//   count     out registered count, always 0..MAX_VAL
//   wrap      out registered pulse after a MAX_VAL<->0 wrap step
//   ovf       out registered sticky wrap flag
//   at_max    out combinational count == MAX_VAL
//   at_min    out combinational count == 0
module mod_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             ovf,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

   // Elaboration-time parameter sanity checks.
   if (WIDTH < 2) begin : g_chk_width
      $error("mod_counter: WIDTH must be >= 2");
   end
   if (MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_chk_max
      $error("mod_counter: MAX_VAL out of range");
   end
   if (PRESCALE < 2) begin : g_chk_prescale
      $error("mod_counter: PRESCALE must be >= 2");
   end

   logic step;

`ifdef COUNTER_PRESCALE_EN
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .en   (en),
      .tick (step)
   );
`else
   assign step = en;
`endif

   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;
   logic             ovf_nxt;

   // Next-state: load beats step; wrap/ovf only come from a wrapping step.
   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
      if (load) begin
         count_nxt = (load_val > MAX_C) ? MAX_C : load_val;
      end else if (step) begin
         if (up_dn == DIR_UP) begin
            if (count != MAX_C) begin
               count_nxt = count + WIDTH'(1);
            end else if (sat_mode == MODE_WRAP) begin
               count_nxt = '0;
               wrap_nxt  = 1'b1;
            end
         end else begin
            if (count != '0) begin
               count_nxt = count - WIDTH'(1);
            end else if (sat_mode == MODE_WRAP) begin
               count_nxt = MAX_C;
               wrap_nxt  = 1'b1;
            end
         end
      end
      // A wrap in the same cycle as clr_ovf leaves the flag set.
      ovf_nxt = wrap_nxt | (ovf & ~clr_ovf);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         wrap  <= wrap_nxt;
         ovf   <= ovf_nxt;
      end
   end

   assign at_max = (count == MAX_C);
   assign at_min = (count == '0);

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (WIDTH=3, MAX_VAL=5, PRESCALE=3).
// Define COUNTER_PRESCALE_EN on both RTL and bench to exercise the prescaler.
module tb_mod_counter;

   localparam int unsigned WIDTH    = 3;
   localparam int unsigned MAX_VAL  = 5;
   localparam int unsigned PRESCALE = 3;

   logic             clk;
   logic             rst;
   logic             en;
   logic             up_dn;
   logic             sat_mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_ovf;
   logic [WIDTH-1:0] count;
   logic             wrap;
   logic             ovf;
   logic             at_max;
   logic             at_min;

   int checks = 0;
   int errors = 0;

   mod_counter #(
      .WIDTH    (WIDTH),
      .MAX_VAL  (MAX_VAL),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up_dn    (up_dn),
      .sat_mode (sat_mode),
      .load     (load),
      .load_val (load_val),
      .clr_ovf  (clr_ovf),
      .count    (count),
      .wrap     (wrap),
      .ovf      (ovf),
      .at_max   (at_max),
      .at_min   (at_min)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge; outputs are sampled 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int c, input int w, input int o);
      chk({tag, ".count"}, int'(count), c);
      chk({tag, ".wrap"},  int'(wrap),  w);
      chk({tag, ".ovf"},   int'(ovf),   o);
   endtask

   initial begin
      int exp;
      rst = 1'b1; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
      load = 1'b1; load_val = 3'd3; clr_ovf = 1'b0;
      #2;
      cyc();
      chk_all("reset", 0, 0, 0);
      chk("reset.at_min", int'(at_min), 1);
      chk("reset.at_max", int'(at_max), 0);
      rst = 1'b0; load = 1'b0;

`ifdef COUNTER_PRESCALE_EN
      // Steps land on the 3rd, 6th and 9th enabled cycle.
      en = 1'b1; up_dn = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("pre.count", int'(count), (i + 1) / 3);
         chk("pre.wrap", int'(wrap), 0);
      end
      // Holds while en=0, then resumes the partial group.
      en = 1'b0;
      cyc(); cyc();
      chk("pre.hold", int'(count), 3);
      en = 1'b1;
      cyc(); cyc();
      chk("pre.partial", int'(count), 3);
      cyc();
      chk("pre.resume", int'(count), 4);
      // Load clears the divider: next step after a full group of three.
      load = 1'b1; load_val = 3'd1;
      cyc();
      chk("pre.load", int'(count), 1);
      load = 1'b0;
      cyc(); cyc();
      chk("pre.after_load2", int'(count), 1);
      cyc();
      chk("pre.after_load3", int'(count), 2);
`else
      // Up-count in wrap mode across the terminal value.
      en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         exp = (i + 1) % 6;
         chk_all("up_wrap", exp, (exp == 0) ? 1 : 0, (i >= 5) ? 1 : 0);
      end

      // Down wrap from 0 to MAX_VAL.
      en = 1'b0; load = 1'b1; load_val = 3'd0; clr_ovf = 1'b1;
      cyc();
      chk_all("load0_clr", 0, 0, 0);
      load = 1'b0; clr_ovf = 1'b0; en = 1'b1; up_dn = 1'b0;
      cyc();
      chk_all("dn_wrap", 5, 1, 1);
      chk("dn_wrap.at_max", int'(at_max), 1);
      cyc();
      chk_all("dn_after", 4, 0, 1);

      // Saturating up from 3.
      en = 1'b0; clr_ovf = 1'b1;
      cyc();
      chk("clr_ovf", int'(ovf), 0);
      clr_ovf = 1'b0; load = 1'b1; load_val = 3'd3;
      cyc();
      chk("load3", int'(count), 3);
      load = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         exp = (i == 0) ? 4 : 5;
         chk_all("sat_up", exp, 0, 0);
         chk("sat_up.at_max", int'(at_max), (exp == 5) ? 1 : 0);
      end
      // Saturating down at 0.
      load = 1'b1; load_val = 3'd0;
      cyc();
      load = 1'b0; up_dn = 1'b0;
      cyc();
      chk_all("sat_dn", 0, 0, 0);
      chk("sat_dn.at_min", int'(at_min), 1);

      // Load clamps and beats en.
      sat_mode = 1'b0; up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 3'd7;
      cyc();
      chk_all("load_clamp", 5, 0, 0);
      load_val = 3'd2;
      cyc();
      chk_all("load2", 2, 0, 0);
      load = 1'b0; en = 1'b0;
      cyc();
      chk("hold", int'(count), 2);

      // Wrap and clr_ovf in the same cycle: wrap wins.
      load = 1'b1; load_val = 3'd5;
      cyc();
      load = 1'b0; en = 1'b1; up_dn = 1'b1; clr_ovf = 1'b1;
      cyc();
      chk_all("wrap_vs_clr", 0, 1, 1);
      en = 1'b0;
      cyc();
      chk_all("clr_after", 0, 0, 0);
      clr_ovf = 1'b0;

      // Direction change each cycle.
      en = 1'b1; up_dn = 1'b1;
      cyc();
      chk("dir.up", int'(count), 1);
      up_dn = 1'b0;
      cyc();
      chk_all("dir.dn", 0, 0, 0);
      cyc();
      chk_all("dir.dn_wrap", 5, 1, 1);

      // Reset mid-count overrides load and en.
      up_dn = 1'b1;
      cyc();
      rst = 1'b1; load = 1'b1; load_val = 3'd3; en = 1'b1;
      cyc();
      chk_all("rst_mid", 0, 0, 0);
      rst = 1'b0; load = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mod_counter
